// File: rtl/glitch_pkg.sv
// Shared state encoding and field widths for the glitch pulse generator.
package glitch_pkg;

    localparam int DELAY_W   = 16;
    localparam int WIDTH_W   = 8;
    localparam int COUNT_W   = 8;
    localparam int SPACING_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        PULSE = 3'd2,
        SPACE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/glitch_pulse_gen.sv
// Timed glitch pulse train: start strobe -> delay, then n pulses of width/spacing.
//
// state | meaning
// IDLE  | waiting for start_i, output inactive
// DELAY | counting down the start-to-first-pulse delay
// PULSE | glitch asserted for width cycles
// SPACE | inactive gap of spacing cycles between pulses
// DONE  | one-cycle completion strobe
module glitch_pulse_gen
    import glitch_pkg::*;
#(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [WIDTH_W-1:0]   width_i,
    input  logic [COUNT_W-1:0]   num_pulses_i,
    input  logic [SPACING_W-1:0] pulse_spacing_i,
    output logic                 glitch_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic INACTIVE = ~ACTIVE_HIGH;

    state_t               state_q, state_n;
    logic [DELAY_W-1:0]   cnt_q, cnt_n;
    logic [COUNT_W-1:0]   pcnt_q, pcnt_n;
    logic [WIDTH_W-1:0]   width_q, width_n;
    logic [SPACING_W-1:0] spacing_q, spacing_n;
    logic [DELAY_W-1:0]   width_reload;

    // Interval counter holds (cycles remaining - 1); terminal count is zero.
    assign width_reload = {{(DELAY_W-WIDTH_W){1'b0}}, width_q} - DELAY_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            width_q   <= '0;
            spacing_q <= '0;
            glitch_o  <= INACTIVE;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            pcnt_q    <= pcnt_n;
            width_q   <= width_n;
            spacing_q <= spacing_n;
            glitch_o  <= (state_n == PULSE) ? ACTIVE_HIGH : INACTIVE;
            busy_o    <= (state_n != IDLE);
            done_o    <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        pcnt_n    = pcnt_q;
        width_n   = width_q;
        spacing_n = spacing_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    width_n   = width_i;
                    spacing_n = pulse_spacing_i;
                    pcnt_n    = num_pulses_i;
                    if (num_pulses_i == '0 || width_i == '0) begin
                        state_n = DONE;
                    end else if (delay_i == '0) begin
                        state_n = PULSE;
                        cnt_n   = {{(DELAY_W-WIDTH_W){1'b0}}, width_i} - DELAY_W'(1);
                    end else begin
                        state_n = DELAY;
                        cnt_n   = delay_i - DELAY_W'(1);
                    end
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_n = PULSE;
                    cnt_n   = width_reload;
                end else begin
                    cnt_n = cnt_q - DELAY_W'(1);
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    pcnt_n = pcnt_q - COUNT_W'(1);
                    if (pcnt_q == COUNT_W'(1)) begin
                        state_n = DONE;
                    end else if (spacing_q == '0) begin
                        state_n = PULSE;
                        cnt_n   = width_reload;
                    end else begin
                        state_n = SPACE;
                        cnt_n   = spacing_q - SPACING_W'(1);
                    end
                end else begin
                    cnt_n = cnt_q - DELAY_W'(1);
                end
            end
            SPACE: begin
                if (cnt_q == '0) begin
                    state_n = PULSE;
                    cnt_n   = width_reload;
                end else begin
                    cnt_n = cnt_q - DELAY_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (abort_i && state_q != IDLE) begin
            state_n = IDLE;
        end
    end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Randomized bench for glitch_pulse_gen with a timeline-based reference model.
module tb_glitch_pulse_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [15:0] delay_i;
    logic [7:0]  width_i;
    logic [7:0]  num_pulses_i;
    logic [15:0] pulse_spacing_i;
    logic        glitch_p, busy_p, done_p;
    logic        glitch_n, busy_n, done_n;

    always #5 clk = ~clk;

    glitch_pulse_gen #(.ACTIVE_HIGH(1'b1)) dut_p (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
        .pulse_spacing_i(pulse_spacing_i),
        .glitch_o(glitch_p), .busy_o(busy_p), .done_o(done_p)
    );

    glitch_pulse_gen #(.ACTIVE_HIGH(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
        .pulse_spacing_i(pulse_spacing_i),
        .glitch_o(glitch_n), .busy_o(busy_n), .done_o(done_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit known  = 1'b0;

    // Reference model: one run described by its start cycle and parameters;
    // outputs for any cycle follow from the pulse timing formulas.
    int run_k    = -100;
    int run_end  = -100;
    int run_done = -100;
    int m_d = 0, m_w = 0, m_n = 0, m_s = 0;
    bit m_zero = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_busy(input int c);
        return (c >= run_k + 1) && (c <= run_end);
    endfunction

    function automatic bit exp_done(input int c);
        return exp_busy(c) && (c == run_done);
    endfunction

    function automatic bit exp_glitch(input int c);
        int t, i, off;
        if (!exp_busy(c) || m_zero) return 1'b0;
        t = c - (run_k + 1 + m_d);
        if (t < 0) return 1'b0;
        i   = t / (m_w + m_s);
        off = t % (m_w + m_s);
        return (i < m_n) && (off < m_w);
    endfunction

    task automatic step(input bit st, input bit ab, input bit rs,
                        input int d, input int w, input int n, input int s);
        @(negedge clk);
        cyc++;
        if (known) begin
            check("glitch",     32'(glitch_p), 32'(exp_glitch(cyc)));
            check("busy",       32'(busy_p),   32'(exp_busy(cyc)));
            check("done",       32'(done_p),   32'(exp_done(cyc)));
            check("glitch_inv", 32'(glitch_n), 32'(!exp_glitch(cyc)));
            check("busy_inv",   32'(busy_n),   32'(exp_busy(cyc)));
            check("done_inv",   32'(done_n),   32'(exp_done(cyc)));
        end
        rst             = rs;
        start_i         = st;
        abort_i         = ab;
        delay_i         = 16'(d);
        width_i         = 8'(w);
        num_pulses_i    = 8'(n);
        pulse_spacing_i = 16'(s);
        if (rs) begin
            run_end = cyc;
            known   = 1'b1;
        end else if (exp_busy(cyc)) begin
            if (ab) run_end = cyc;
        end else if (st) begin
            run_k  = cyc;
            m_d    = d;
            m_w    = w;
            m_n    = n;
            m_s    = s;
            m_zero = (n == 0) || (w == 0);
            run_done = m_zero ? cyc + 1 : cyc + 1 + d + n * w + (n - 1) * s;
            run_end  = run_done;
        end
    endtask

    task automatic idle(input int nc);
        for (int i = 0; i < nc; i++)
            step(1'b0, 1'b0, 1'b0, int'($urandom % 9), int'($urandom % 9),
                 int'($urandom % 9), int'($urandom % 9));
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        delay_i = '0; width_i = '0; num_pulses_i = '0; pulse_spacing_i = '0;

        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(8);

        // basic train with ignored restart and parameter change mid-run
        step(1, 0, 0, 3, 2, 3, 4);
        idle(5);
        step(1, 0, 0, 1, 7, 1, 0);
        idle(8);
        step(1, 0, 0, 0, 1, 5, 2);
        idle(8);

        // zero delay, merged pulses
        step(1, 0, 0, 0, 5, 2, 0);
        idle(12);

        // degenerate runs; second start lands in the DONE cycle and is ignored
        step(1, 0, 0, 3, 2, 0, 1);
        step(1, 0, 0, 2, 2, 2, 2);
        idle(2);
        step(1, 0, 0, 3, 0, 2, 1);
        idle(2);

        // abort mid-pulse, then immediate restart
        step(1, 0, 0, 0, 10, 1, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        idle(5);

        // reset during SPACE
        step(1, 0, 0, 0, 2, 3, 6);
        idle(4);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom % 32 == 0) ? int'($urandom % 300) : int'($urandom % 7);
            step(($urandom % 4) == 0, ($urandom % 80) == 0, ($urandom % 200) == 0,
                 d, int'($urandom % 5), int'($urandom % 5), int'($urandom % 6));
        end
        idle(400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Downstream consumer of the UART command handler's configuration registers. It turns a one-cycle start strobe into a precisely timed train of glitch pulses on `glitch_o`. Delay, width, pulse count and spacing are sampled at start and held for the whole run. The block drives the glitch switch/MOSFET pad and reports `busy_o` and `done_o` back for status/readback logic.

## Interface
Parameters:
- `ACTIVE_HIGH`, default 1: polarity of `glitch_o`.
  - 1: asserted level is 1.
  - 0: output is inverted; idle level is 1.

Ports:
- `clk`  in  1  system clock. The block uses one clock.
- `rst`  in  1  reset. It is synchronous and active-high.
- `start_i`  in  1  one-cycle start strobe, driven by the handler's `pulse_en`.
- `abort_i`  in  1  synchronous abort. It is level-sampled each cycle.
- `delay_i`  in  16  cycles from start to the first pulse.
- `width_i`  in  8  high time of each pulse, in cycles.
- `num_pulses_i`  in  8  number of pulses, 0..255.
- `pulse_spacing_i`  in  16  low time between consecutive pulses, in cycles.
- `glitch_o`  out  1  registered glitch output.
- `busy_o`  out  1  high while a run is in progress.
- `done_o`  out  1  one-cycle strobe at normal completion.

## Operation
- States:
  - IDLE
  - DELAY
  - PULSE
  - SPACE
  - DONE
- Reset values:
  - state IDLE.
  - `glitch_o` = inactive level (`!ACTIVE_HIGH`).
  - `busy_o` = 0, `done_o` = 0.
  - All counters and shadow registers = 0.
- IDLE:
  - When `start_i`=1, latch all four parameters into shadow registers.
  - If `num_pulses_i`==0 or `width_i`==0, go to DONE.
  - If `delay_i`==0, go directly to PULSE.
  - Otherwise go to DELAY.
- DELAY: hold inactive for exactly `delay` cycles, then go to PULSE.
- PULSE:
  - Assert `glitch_o` for exactly `width` cycles.
  - At the end, decrement the remaining-pulse count.
  - If the count reaches 0, go to DONE.
  - Otherwise go to SPACE; if `spacing`==0, go straight back to PULSE.
- SPACE: hold inactive for exactly `spacing` cycles, then go to PULSE.
- DONE:
  - `glitch_o` is inactive and `done_o`=1 for one cycle.
  - Then go to IDLE.
- `start_i` is accepted only in IDLE. It is ignored while `busy_o`=1, including the DONE cycle.
- `abort_i`=1 in any non-IDLE state:
  - The next cycle has `glitch_o` inactive, state IDLE, `busy_o`=0, and no `done_o`.
  - `abort_i` has priority over all other transitions.
  - In IDLE, `abort_i` is a no-op; start takes effect if both are asserted.
- Shadow registers isolate the run. Input changes during a run have no effect until the next start.
- Counter widths:
  - Interval counter: 16-bit, shared by DELAY, PULSE and SPACE, reloaded on each state entry.
  - Pulse counter: 8-bit.
  - No wrap-around is possible. Maximum values are 65535, 255 and 65535 cycles.
- `spacing`==0 gives a continuous active level of n×`width` cycles with no gaps.

## Timing
- Let k be the cycle in which `start_i`=1 is sampled in IDLE.
- Pulse i (0-based) is active on cycles k+1+delay+i·(width+spacing) through that value + width − 1.
- `done_o` fires on cycle k+1+delay+n·width+(n−1)·spacing. This is the first inactive cycle after the last pulse.
- `busy_o` is high from k+1 through the `done_o` cycle inclusive. A new start is accepted on the following cycle.
- Zero case (n==0 or width==0): `done_o` and `busy_o` are high on k+1 only, and `glitch_o` never asserts.
- `rst` mid-run: on the next cycle all reset values apply and no `done_o` is generated.
- All outputs are registered, with no combinational path from inputs.

## Structure
- Package `glitch_pkg` holds:
  - the state encoding localparams (IDLE=0, DELAY=1, PULSE=2, SPACE=3, DONE=4, 3-bit);
  - the width constants DELAY_W=16, WIDTH_W=8, COUNT_W=8, SPACING_W=16.
- No sub-module is required. The shared loadable 16-bit down counter stays inline.

## Test plan
- Basic train: delay=3, width=2, n=3, spacing=4, start at cycle 10.
  - `glitch_o` active on cycles 14–15, 20–21 and 26–27.
  - `done_o` on 28; `busy_o` high 11–28.
- Zero delay and merged pulses: delay=0, width=5, n=2, spacing=0, start at 0.
  - `glitch_o` active on 1–10 continuously.
  - `done_o` on 11.
- Degenerate runs: n=0, then width=0, each started at cycle 0.
  - `done_o` and `busy_o` on cycle 1 only; `glitch_o` never active.
- Abort mid-pulse: width=10, n=1, delay=0, `abort_i` asserted at cycle 4.
  - `glitch_o` inactive and `busy_o`=0 from cycle 5; no `done_o`.
  - A start at cycle 5 is accepted.
- Ignored restart and parameter change: during a run, pulse `start_i` again and change `width_i`.
  - Timing is unchanged; only one `done_o` occurs.
- Polarity and reset: with `ACTIVE_HIGH`=0, `glitch_o`=1 after reset and 0 during pulses.
  - `rst` asserted mid-SPACE returns `glitch_o` to 1 the next cycle, with `busy_o`=0.
